// File: rtl/rr_arb_mux_pkg.sv
// Shared types, defaults and helpers for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

   localparam int DEF_WIDTH = 5;
   localparam int DEF_NCH   = 4;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // Index width for n items; callers keep n >= 2 so the result is never zero.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational grant selection: round-robin search from ptr, or a fixed channel.
module rr_arb_pick
   import rr_arb_mux_pkg::*;
#(
   parameter  int NCH  = DEF_NCH,
   localparam int SELW = clog2(NCH)
) (
   input  logic [NCH-1:0]  in_valid,
   input  logic [SELW-1:0] ptr,
   input  logic            mode,
   input  logic [SELW-1:0] fixed_sel,
   output logic [NCH-1:0]  grant,
   output logic [SELW-1:0] grant_idx
);

   logic found;
   int   c;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      c         = 0;
      if (mode == MODE_FIXED) begin
         // Comparing against every legal index means an out-of-range select never grants.
         for (int i = 0; i < NCH; i++) begin
            if (fixed_sel == SELW'(i) && in_valid[i]) begin
               grant[i]  = 1'b1;
               grant_idx = SELW'(i);
            end
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            c = (int'(ptr) + k) % NCH;
            if (!found && in_valid[c]) begin
               found     = 1'b1;
               grant[c]  = 1'b1;
               grant_idx = SELW'(c);
            end
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux with a one-word registered output stage.
// Optional out_par (even parity of out_data) when RR_ARB_MUX_PARITY_EN is defined.
module rr_arb_mux
   import rr_arb_mux_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NCH   = DEF_NCH,
   localparam int SELW  = clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode_fixed,
   input  logic [SELW-1:0]      fixed_sel,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_ch
`ifdef RR_ARB_MUX_PARITY_EN
   ,
   output logic                 out_par
`endif
);

   logic [SELW-1:0]  ptr;
   logic [NCH-1:0]   grant;
   logic [SELW-1:0]  grant_idx;
   logic             load_en;
   logic             xfer_in;
   logic [WIDTH-1:0] sel_data;

   rr_arb_pick #(.NCH(NCH)) u_pick (
      .in_valid  (in_valid),
      .ptr       (ptr),
      .mode      (mode_fixed),
      .fixed_sel (fixed_sel),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign load_en  = ~out_valid | out_ready;
   // rst_n gating keeps every channel blocked for the whole reset window.
   assign in_ready = (rst_n && load_en) ? grant : '0;
   assign xfer_in  = |in_ready;
   assign sel_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
`ifdef RR_ARB_MUX_PARITY_EN
         out_par   <= 1'b0;
`endif
      end else if (xfer_in) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_ch    <= grant_idx;
`ifdef RR_ARB_MUX_PARITY_EN
         out_par   <= ^sel_data;
`endif
         if (mode_fixed == MODE_RR) begin
            ptr <= (grant_idx == SELW'(NCH-1)) ? '0 : grant_idx + SELW'(1);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: per-cycle reference model plus directed literal checks.
module tb_rr_arb_mux;

   logic        clk;
   logic        rst_n;
   logic [19:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic        mode_fixed;
   logic [1:0]  fixed_sel;
   logic [4:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_ch;
`ifdef RR_ARB_MUX_PARITY_EN
   logic        out_par;
   logic        out_par3;
`endif

   // Three-channel instance: lets a select value >= NCH be driven.
   logic [14:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [1:0]  fixed_sel3;
   logic [4:0]  out_data3;
   logic        out_valid3;
   logic [1:0]  out_ch3;

   int n_checks = 0;
   int n_err    = 0;

   rr_arb_mux dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode_fixed(mode_fixed), .fixed_sel(fixed_sel),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_ch(out_ch)
`ifdef RR_ARB_MUX_PARITY_EN
      , .out_par(out_par)
`endif
   );

   rr_arb_mux #(.WIDTH(5), .NCH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
      .in_ready(in_ready3), .mode_fixed(1'b1), .fixed_sel(fixed_sel3),
      .out_data(out_data3), .out_valid(out_valid3), .out_ready(1'b1),
      .out_ch(out_ch3)
`ifdef RR_ARB_MUX_PARITY_EN
      , .out_par(out_par3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_grant(input logic [3:0] v, input int p,
                                            input logic fx, input int sel);
      if (fx) return (sel < 4 && v[sel]) ? 4'(1 << sel) : 4'b0;
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return 4'(1 << ((p + k) % 4));
      end
      return 4'b0;
   endfunction

   function automatic int onehot_idx(input logic [3:0] g);
      for (int i = 0; i < 4; i++) if (g[i]) return i;
      return 0;
   endfunction

   // Reference model: one held word plus the rotation pointer.
   logic       m_valid;
   logic [4:0] m_data;
   int         m_ch;
   int         m_ptr;

   always @(negedge clk) begin
      logic [3:0] g;
      logic [3:0] er;
      int         idx;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_ch    = 0;
         m_ptr   = 0;
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_out_ch", out_ch, 0);
      end else begin
         g  = exp_grant(in_valid, m_ptr, mode_fixed, int'(fixed_sel));
         er = (!m_valid || out_ready) ? g : 4'b0;
         chk("mdl_in_ready", in_ready, er);
         chk("mdl_out_valid", out_valid, m_valid);
         chk("mdl_out_data", out_data, m_data);
         chk("mdl_out_ch", out_ch, m_ch);
`ifdef RR_ARB_MUX_PARITY_EN
         chk("mdl_out_par", out_par, ^m_data);
`endif
         if (er != 0) begin
            idx     = onehot_idx(er);
            m_valid = 1'b1;
            m_data  = in_data[idx*5 +: 5];
            m_ch    = idx;
            if (!mode_fixed) m_ptr = (idx + 1) % 4;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      in_data    = {5'h13, 5'h15, 5'h0B, 5'h0A};
      in_valid   = 4'b1111;
      mode_fixed = 1'b0;
      fixed_sel  = 2'd0;
      out_ready  = 1'b1;
      in_data3   = {5'h03, 5'h02, 5'h01};
      in_valid3  = 3'b111;
      fixed_sel3 = 2'd3;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_in_ready", in_ready, 4'b0000);
      rst_n = 1'b1;

      // Round-robin fairness: 0,1,2,3,0,1,2,3 one word per cycle.
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("rr_seq_ch", out_ch, i % 4);
         chk("rr_seq_valid", out_valid, 1);
      end

      // Backpressure on a held ch3 word.
      out_ready = 1'b0;
      in_valid  = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bp_data", out_data, 5'h13);
         chk("bp_ch", out_ch, 3);
         chk("bp_in_ready", in_ready, 4'b0000);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 4'b0001);
      cyc();
      chk("bp_after_ch0", out_ch, 0);
      cyc();
      chk("bp_after_ch2", out_ch, 2);
      in_valid = 4'b0000;
      cyc();
      chk("drain_valid", out_valid, 0);

      // Skip: ptr=1 with channels 0 and 3 valid.
      in_valid = 4'b0001;
      cyc();
      chk("skip_setup_ch", out_ch, 0);
      in_valid = 4'b1001;
      cyc();
      chk("skip_ch3", out_ch, 3);
      cyc();
      chk("skip_wrap_ch0", out_ch, 0);

      // Fixed mode, ptr left at 1.
      mode_fixed = 1'b1;
      fixed_sel  = 2'd2;
      in_valid   = 4'b1111;
      #1;
      chk("fixed_in_ready", in_ready, 4'b0100);
      cyc();
      chk("fixed_data", out_data, 5'h15);
      chk("fixed_ch", out_ch, 2);
      out_ready  = 1'b0;
      fixed_sel  = 2'd0;
      mode_fixed = 1'b0;
      cyc();
      chk("cfg_hold_ch", out_ch, 2);
      chk("cfg_hold_data", out_data, 5'h15);
      out_ready = 1'b1;
      cyc();
      chk("fixed_kept_ptr", out_ch, 1);

`ifdef RR_ARB_MUX_PARITY_EN
      mode_fixed    = 1'b1;
      fixed_sel     = 2'd1;
      in_data[9:5]  = 5'b10110;
      cyc();
      chk("par_one", out_par, 1);
      in_data[9:5]  = 5'b10010;
      cyc();
      chk("par_zero", out_par, 0);
      in_data[9:5]  = 5'h0B;
      mode_fixed    = 1'b0;
`endif

      // Select beyond channel count on the three-channel instance.
      fixed_sel3 = 2'd3;
      #1;
      chk("sel_oob_ready", in_ready3, 3'b000);
      fixed_sel3 = 2'd2;
      #1;
      chk("sel_2_ready", in_ready3, 3'b100);

      // Reset in the middle of a held word.
      in_valid  = 4'b1111;
      cyc();
      out_ready = 1'b0;
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_data, 0);
      chk("midrst_ready", in_ready, 4'b0000);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      cyc();
      chk("postrst_ch0", out_ch, 0);
      chk("postrst_valid", out_valid, 1);
      repeat (3) cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
